// File: rtl/ov2640_capture.sv
// OV2640 DVP capture: pairs RGB565 bytes into RGB444 pixels and writes them to a linear frame buffer.
// Settling frames are skipped after configuration; frame completion and pixel-count errors are reported.
module ov2640_capture #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_W      = 19,
    parameter int SKIP_FRAMES = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_done,
    input  logic              cam_vsync,
    input  logic              cam_href,
    input  logic [7:0]        cam_data,
    output logic              pix_we,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [11:0]       pix_rgb,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int              NPIX    = H_RES * V_RES;
    localparam int              CW      = ADDR_W + 2;
    localparam logic [CW-1:0]   NPIX_C  = CW'(NPIX);
    localparam logic [CW-1:0]   CNT_MAX = '1;
    localparam int              SW      = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SKIP,
        S_WAIT_SOF,
        S_CAPTURE
    } state_t;

    state_t          state;
    logic            vs_r;
    logic            vs_d;
    logic            hr_r;
    logic [7:0]      d_r;
    logic            phase;
    logic [6:0]      hi_keep;
    logic            pair_vld;
    logic [11:0]     pair_rgb;
    logic [CW-1:0]   pair_cnt;
    logic [CW-1:0]   cnt_inc;
    logic [SW-1:0]   skip_cnt;
    logic            vs_fall;
    logic            vs_rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_r <= 1'b0;
            vs_d <= 1'b0;
            hr_r <= 1'b0;
            d_r  <= 8'h00;
        end else begin
            vs_r <= cam_vsync;
            vs_d <= vs_r;
            hr_r <= cam_href;
            d_r  <= cam_data;
        end
    end

    assign vs_fall = vs_d & ~vs_r;
    assign vs_rise = ~vs_d & vs_r;

    // Pair count including a pair that completes on this edge; saturates so a huge frame never aliases to NPIX.
    always_comb begin
        cnt_inc = pair_cnt;
        if (pair_vld && (pair_cnt != CNT_MAX)) begin
            cnt_inc = pair_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            phase      <= 1'b0;
            hi_keep    <= 7'h00;
            pair_vld   <= 1'b0;
            pair_rgb   <= 12'h000;
            pair_cnt   <= '0;
            skip_cnt   <= '0;
            pix_we     <= 1'b0;
            pix_addr   <= '0;
            pix_rgb    <= 12'h000;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'h00;
        end else begin
            pix_we     <= 1'b0;
            frame_done <= 1'b0;
            pair_vld   <= 1'b0;

            if (!cfg_done) begin
                // Sensor reconfiguring: drop any partial frame and restart the skip sequence later.
                state    <= S_IDLE;
                phase    <= 1'b0;
                pair_cnt <= '0;
                skip_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        skip_cnt <= '0;
                        phase    <= 1'b0;
                        state    <= S_SKIP;
                    end

                    S_SKIP: begin
                        if (SKIP_FRAMES == 0) begin
                            state <= S_WAIT_SOF;
                        end else if (vs_fall) begin
                            if (int'(skip_cnt) == SKIP_FRAMES - 1) begin
                                state <= S_WAIT_SOF;
                            end else begin
                                skip_cnt <= skip_cnt + SW'(1);
                            end
                        end
                    end

                    S_WAIT_SOF: begin
                        if (vs_fall) begin
                            state    <= S_CAPTURE;
                            pair_cnt <= '0;
                            phase    <= 1'b0;
                        end
                    end

                    S_CAPTURE: begin
                        // A pair finishing on the same edge as end-of-frame is still written and counted here.
                        if (pair_vld && (pair_cnt < NPIX_C)) begin
                            pix_we   <= 1'b1;
                            pix_addr <= pair_cnt[ADDR_W-1:0];
                            pix_rgb  <= pair_rgb;
                        end

                        if (vs_rise) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            if (cnt_inc != NPIX_C) begin
                                frame_err <= 1'b1;
                            end
                            pair_cnt <= '0;
                        end else begin
                            pair_cnt <= cnt_inc;
                        end

                        if (hr_r && !vs_r) begin
                            if (!phase) begin
                                hi_keep <= {d_r[7:4], d_r[2:0]};
                                phase   <= 1'b1;
                            end else begin
                                pair_vld <= 1'b1;
                                pair_rgb <= {hi_keep, d_r[7], d_r[4:1]};
                                phase    <= 1'b0;
                            end
                        end else begin
                            phase <= 1'b0;
                        end
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov2640_capture.sv
// Bench for ov2640_capture at 4x2 pixels with two skip frames; frames are checked against a
// line/byte-level model of expected writes, frame counts and error status.
module tb_ov2640_capture;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;
    localparam int SK = 2;
    localparam int NP = H * V;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_done;
    logic          cam_vsync;
    logic          cam_href;
    logic [7:0]    cam_data;
    logic          pix_we;
    logic [AW-1:0] pix_addr;
    logic [11:0]   pix_rgb;
    logic          frame_done;
    logic          frame_err;
    logic [7:0]    frame_cnt;

    always #5 clk = ~clk;

    ov2640_capture #(
        .H_RES(H), .V_RES(V), .ADDR_W(AW), .SKIP_FRAMES(SK)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cfg_done(cfg_done),
        .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
        .pix_we(pix_we), .pix_addr(pix_addr), .pix_rgb(pix_rgb),
        .frame_done(frame_done), .frame_err(frame_err), .frame_cnt(frame_cnt)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int wr_addr_q[$];
    int wr_rgb_q[$];
    int wr_cyc_q[$];
    int done_total = 0;

    always @(negedge clk) begin
        if (pix_we) begin
            wr_addr_q.push_back(int'(pix_addr));
            wr_rgb_q.push_back(int'(pix_rgb));
            wr_cyc_q.push_back(cyc);
        end
        if (frame_done) done_total++;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Model: RGB565 word is {hi,lo}; keep the top bits of each colour component.
    function automatic int ref_pack(input logic [7:0] hi, input logic [7:0] lo);
        logic [4:0] r;
        logic [5:0] g;
        logic [4:0] b;
        {r, g, b} = {hi, lo};
        return int'({r[4:1], g[5:2], b[4:1]});
    endfunction

    int         exp_cnt  = 0;
    bit         exp_err  = 1'b0;
    int         skip_left = SK;
    logic [7:0] byte_q[$];
    int         line_len[$];
    int         last_base;

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            cam_href = 1'b0;
            cam_data = 8'h00;
        end
    endtask

    task automatic fill_rand(input int l0, input int l1);
        byte_q.delete();
        line_len = '{l0, l1};
        repeat (l0 + l1) byte_q.push_back(8'($urandom));
    endtask

    task automatic run_frame(input bit tight);
        bit         captured;
        int         bi;
        int         nexp;
        int         done_base;
        logic [7:0] hi;
        int         exp_rgb[$];
        int         exp_cyc[$];

        captured = (skip_left == 0);
        if (!captured) skip_left--;
        last_base = wr_addr_q.size();
        done_base = done_total;
        repeat (3) begin
            @(negedge clk);
            cam_vsync = 1'b1;
            cam_href  = 1'b0;
        end
        @(negedge clk);
        cam_vsync = 1'b0;
        idle(2);
        bi = 0;
        hi = 8'h00;
        for (int l = 0; l < line_len.size(); l++) begin
            for (int b = 0; b < line_len[l]; b++) begin
                @(negedge clk);
                cam_href = 1'b1;
                cam_data = byte_q[bi];
                bi++;
                if (b % 2 == 0) hi = cam_data;
                else begin
                    exp_rgb.push_back(ref_pack(hi, cam_data));
                    exp_cyc.push_back(cyc);
                end
            end
            if (!(tight && l == line_len.size() - 1)) idle(2);
        end
        @(negedge clk);
        cam_href  = 1'b0;
        cam_data  = 8'h00;
        cam_vsync = 1'b1;
        repeat (4) @(negedge clk);

        nexp = captured ? ((exp_rgb.size() < NP) ? exp_rgb.size() : NP) : 0;
        check("write_count", wr_addr_q.size() - last_base, nexp);
        for (int i = 0; i < nexp && last_base + i < wr_addr_q.size(); i++) begin
            check("write_addr", wr_addr_q[last_base + i], i);
            check("write_rgb", wr_rgb_q[last_base + i], exp_rgb[i]);
            check("write_latency", wr_cyc_q[last_base + i] - exp_cyc[i], 3);
        end
        if (captured) begin
            exp_cnt = (exp_cnt + 1) % 256;
            if (exp_rgb.size() != NP) exp_err = 1'b1;
        end
        check("frame_done_count", done_total - done_base, captured ? 1 : 0);
        check("frame_cnt", int'(frame_cnt), exp_cnt);
        check("frame_err", int'(frame_err), int'(exp_err));
    endtask

    typedef struct {
        logic [7:0]  hi;
        logic [7:0]  lo;
        logic [11:0] rgb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int base;
        int done_base;

        tbl[0] = '{8'hF8, 8'h1F, 12'hF0F};
        tbl[1] = '{8'h07, 8'hE0, 12'h0F0};
        tbl[2] = '{8'hFF, 8'hFF, 12'hFFF};
        tbl[3] = '{8'h00, 8'h00, 12'h000};
        tbl[4] = '{8'hA5, 8'h5A, 12'hAAD};
        tbl[5] = '{8'h12, 8'h34, 12'h14A};
        tbl[6] = '{8'h80, 8'h01, 12'h800};
        tbl[7] = '{8'h00, 8'h80, 12'h010};

        rst_n = 1'b0; cfg_done = 1'b0; cam_vsync = 1'b1; cam_href = 1'b0; cam_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_pix_we", int'(pix_we), 0);
        check("reset_pix_addr", int'(pix_addr), 0);
        check("reset_pix_rgb", int'(pix_rgb), 0);
        check("reset_frame_done", int'(frame_done), 0);
        check("reset_frame_err", int'(frame_err), 0);
        check("reset_frame_cnt", int'(frame_cnt), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Two skipped frames, then the packing table as the first captured frame.
        cfg_done  = 1'b1;
        skip_left = SK;
        fill_rand(8, 8); run_frame(1'b0);
        fill_rand(8, 8); run_frame(1'b0);
        byte_q.delete();
        line_len = '{8, 8};
        foreach (tbl[i]) begin
            byte_q.push_back(tbl[i].hi);
            byte_q.push_back(tbl[i].lo);
        end
        run_frame(1'b0);
        for (int i = 0; i < 8 && last_base + i < wr_rgb_q.size(); i++)
            check("table_rgb", wr_rgb_q[last_base + i], int'(tbl[i].rgb));

        repeat (4) begin
            fill_rand(8, 8);
            run_frame(1'($urandom_range(0, 1)));
        end
        fill_rand(8, 8); run_frame(1'b1);

        // Odd trailing byte dropped: 4 + 3 pairs.
        fill_rand(9, 6); run_frame(1'b0);
        // Overflow: 10 pairs, only 8 written.
        fill_rand(12, 8); run_frame(1'b1);
        fill_rand(8, 8); run_frame(1'b0);

        // cfg_done dropped after three writes.
        base = wr_addr_q.size();
        done_base = done_total;
        repeat (3) begin @(negedge clk); cam_vsync = 1'b1; end
        @(negedge clk); cam_vsync = 1'b0;
        idle(2);
        for (int b = 0; b < 6; b++) begin
            @(negedge clk); cam_href = 1'b1; cam_data = 8'($urandom);
        end
        idle(5);
        cfg_done = 1'b0;
        for (int b = 0; b < 4; b++) begin
            @(negedge clk); cam_href = 1'b1; cam_data = 8'($urandom);
        end
        idle(2);
        @(negedge clk); cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        check("drop_write_count", wr_addr_q.size() - base, 3);
        for (int i = 0; i < 3 && base + i < wr_addr_q.size(); i++)
            check("drop_write_addr", wr_addr_q[base + i], i);
        check("drop_no_frame_done", done_total - done_base, 0);
        check("drop_frame_cnt", int'(frame_cnt), exp_cnt);
        cfg_done  = 1'b1;
        skip_left = SK;
        repeat (3) begin fill_rand(8, 8); run_frame(1'b0); end

        // Asynchronous reset in the middle of a line.
        repeat (3) begin @(negedge clk); cam_vsync = 1'b1; end
        @(negedge clk); cam_vsync = 1'b0;
        idle(2);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); cam_href = 1'b1; cam_data = 8'($urandom);
        end
        #2 rst_n = 1'b0;
        #1;
        check("arst_pix_we", int'(pix_we), 0);
        check("arst_pix_addr", int'(pix_addr), 0);
        check("arst_pix_rgb", int'(pix_rgb), 0);
        check("arst_frame_err", int'(frame_err), 0);
        check("arst_frame_cnt", int'(frame_cnt), 0);
        @(negedge clk); rst_n = 1'b1;
        exp_cnt = 0; exp_err = 1'b0; skip_left = SK;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk); cam_href = 1'b1; cam_data = 8'($urandom);
        end
        idle(2);
        @(negedge clk); cam_vsync = 1'b1;
        repeat (4) @(negedge clk);
        repeat (3) begin fill_rand(8, 8); run_frame(1'($urandom_range(0, 1))); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
